// File: rtl/perf_monitor.sv
// perf_monitor: counts cycles, retired instructions (pc changes) and generic
// event strobes while the core runs, freezes once the core halts, and returns
// any counter through a registered read-select port.

// One saturating counter with a sticky overflow flag.
module perf_sat_cnt #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 ovf
);
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    // Next value: clear wins; an increment at all-ones holds and flags overflow.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc) begin
            if (&cnt_q) ovf_d = 1'b1;
            else        cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter and flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;
endmodule

module perf_monitor #(
    parameter int  PC_WIDTH   = 10,
    parameter int  CNT_WIDTH  = 32,
    parameter int  NUM_EVENTS = 2,
    localparam int SEL_WIDTH  = $clog2(NUM_EVENTS + 2)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    enable,
    input  logic [PC_WIDTH-1:0]     pc,
    input  logic                    halted,
    input  logic [NUM_EVENTS-1:0]   event_in,
    input  logic [SEL_WIDTH-1:0]    rd_sel,
    output logic [CNT_WIDTH-1:0]    rd_data,
    output logic                    done,
    output logic [NUM_EVENTS+1:0]   overflow
);
    localparam int NUM_CNT = NUM_EVENTS + 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                             state_q, state_d;
    logic [PC_WIDTH-1:0]                last_pc_q, last_pc_d;
    logic                               pc_valid_q, pc_valid_d;
    logic [CNT_WIDTH-1:0]               rd_data_q, rd_data_d;
    logic                               count_en;
    logic                               retire;
    logic [NUM_CNT-1:0]                 inc_vec;
    logic [NUM_CNT-1:0][CNT_WIDTH-1:0]  cnt_all;
    logic [NUM_CNT-1:0]                 ovf_all;

    // A counting cycle is live (not DONE), enabled, not halting and not clearing.
    assign count_en = (state_q != DONE) && enable && !halted && !clear;
    // First counted cycle always retires; afterwards only a pc change does,
    // so pc motion during a pause is seen once on resume.
    assign retire   = !pc_valid_q || (pc != last_pc_q);

    assign inc_vec[0]           = count_en;
    assign inc_vec[1]           = count_en && retire;
    assign inc_vec[NUM_CNT-1:2] = event_in & {NUM_EVENTS{count_en}};

    // One saturating counter per index: cycles, instructions, then events.
    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        perf_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clear (clear),
            .inc   (inc_vec[i]),
            .cnt   (cnt_all[i]),
            .ovf   (ovf_all[i])
        );
    end

    // FSM next state; clear overrides halted/enable, DONE only leaves via clear.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (enable) state_d = halted ? DONE : RUN;
                RUN:     if (enable && halted) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Last-pc tracking only advances on counting cycles.
    always_comb begin
        last_pc_d  = last_pc_q;
        pc_valid_d = pc_valid_q;
        if (clear) begin
            pc_valid_d = 1'b0;
        end else if (count_en) begin
            last_pc_d  = pc;
            pc_valid_d = 1'b1;
        end
    end

    // Read mux; indices beyond the last counter return zero.
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NUM_CNT; i++)
            if (rd_sel == SEL_WIDTH'(i)) rd_data_d = cnt_all[i];
    end

    // State, pc tracking and read-data registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            last_pc_q  <= '0;
            pc_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_pc_q  <= last_pc_d;
            pc_valid_q <= pc_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign done     = (state_q == DONE);
    assign overflow = ovf_all;
endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: default instance (A) plus a 4-bit,
// 3-event instance (B) for saturation and out-of-range read select.
module tb_perf_monitor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults (PC 10, CNT 32, 2 events, 2-bit select)
    logic        rst_a, clr_a, en_a, hlt_a;
    logic [9:0]  pc_a;
    logic [1:0]  ev_a;
    logic [1:0]  sel_a;
    logic [31:0] rd_a;
    logic        done_a;
    logic [3:0]  ovf_a;

    // Instance B: CNT 4, 3 events, 3-bit select
    logic        rst_b, clr_b, en_b, hlt_b;
    logic [9:0]  pc_b;
    logic [2:0]  ev_b;
    logic [2:0]  sel_b;
    logic [3:0]  rd_b;
    logic        done_b;
    logic [4:0]  ovf_b;

    int n_vec = 0;
    int n_err = 0;

    perf_monitor u_a (
        .clk(clk), .reset(rst_a), .clear(clr_a), .enable(en_a), .pc(pc_a),
        .halted(hlt_a), .event_in(ev_a), .rd_sel(sel_a), .rd_data(rd_a),
        .done(done_a), .overflow(ovf_a)
    );

    perf_monitor #(.PC_WIDTH(10), .CNT_WIDTH(4), .NUM_EVENTS(3)) u_b (
        .clk(clk), .reset(rst_b), .clear(clr_b), .enable(en_b), .pc(pc_b),
        .halted(hlt_b), .event_in(ev_b), .rd_sel(sel_b), .rd_data(rd_b),
        .done(done_b), .overflow(ovf_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd_a_chk(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        sel_a = sel;
        tick();
        chk(tag, rd_a, exp);
    endtask

    task automatic rd_b_chk(input string tag, input logic [2:0] sel, input logic [31:0] exp);
        sel_b = sel;
        tick();
        chk(tag, 32'(rd_b), exp);
    endtask

    initial begin
        rst_a = 0; clr_a = 0; en_a = 0; hlt_a = 0; pc_a = 0; ev_a = 0; sel_a = 0;
        rst_b = 0; clr_b = 0; en_b = 0; hlt_b = 0; pc_b = 0; ev_b = 0; sel_b = 0;
        #12;
        chk("reset_rd", rd_a, 0);
        chk("reset_done", 32'(done_a), 0);
        chk("reset_ovf", 32'(ovf_a), 0);
        rst_a = 1; rst_b = 1;
        tick();

        // --- Test 1: pc 0,1,1,2,3 with event0 on cycles 2 and 4, then halt
        en_a = 1;
        pc_a = 10'd0; ev_a = 2'b00; tick();
        pc_a = 10'd1; ev_a = 2'b01; tick();
        pc_a = 10'd1; ev_a = 2'b00; tick();
        pc_a = 10'd2; ev_a = 2'b01; tick();
        pc_a = 10'd3; ev_a = 2'b00; tick();
        chk("t1_done_pre", 32'(done_a), 0);
        hlt_a = 1; tick();
        chk("t1_done", 32'(done_a), 1);
        // activity while DONE must not move anything
        hlt_a = 0; pc_a = 10'd9; ev_a = 2'b11; tick(3);
        ev_a = 2'b00; en_a = 0;
        chk("t1_done_hold", 32'(done_a), 1);

        // --- Test 6: readback with 1-cycle latency
        rd_a_chk("t6_cycles", 2'd0, 5);
        rd_a_chk("t6_instr",  2'd1, 4);
        rd_a_chk("t6_ev0",    2'd2, 2);
        rd_a_chk("t6_ev1",    2'd3, 0);
        chk("t6_ovf", 32'(ovf_a), 0);

        // --- Test 3: pause with pc moving 5->6->7, resume at 7
        clr_a = 1; tick(); clr_a = 0;
        chk("t3_clr_done", 32'(done_a), 0);
        en_a = 1; pc_a = 10'd5; tick(2);            // cycles=2 instr=1
        en_a = 0; pc_a = 10'd5; tick();
        pc_a = 10'd6; tick();
        pc_a = 10'd7; tick();
        en_a = 1; pc_a = 10'd7; tick();             // cycles=3 instr=2
        en_a = 0;
        rd_a_chk("t3_cycles", 2'd0, 3);
        rd_a_chk("t3_instr",  2'd1, 2);
        chk("t3_done", 32'(done_a), 0);

        // --- Test 4: clear and halted together while in RUN
        en_a = 1; hlt_a = 1; clr_a = 1; tick();
        clr_a = 0; hlt_a = 0; en_a = 0;
        chk("t4_done", 32'(done_a), 0);
        chk("t4_ovf", 32'(ovf_a), 0);
        rd_a_chk("t4_cycles", 2'd0, 0);
        rd_a_chk("t4_instr",  2'd1, 0);
        // FSM went to IDLE, not DONE: it counts again
        en_a = 1; pc_a = 10'd1; tick(); en_a = 0;
        rd_a_chk("t4_recount", 2'd0, 1);
        chk("t4_done2", 32'(done_a), 0);

        // --- Test 5: asynchronous reset mid-run
        clr_a = 1; tick(); clr_a = 0;
        sel_a = 2'd0; en_a = 1; tick(3);
        chk("t5_preinc", rd_a, 2);                  // rd_data lags the increment
        #3 rst_a = 0;
        #1;
        chk("t5_rst_rd", rd_a, 0);
        chk("t5_rst_done", 32'(done_a), 0);
        chk("t5_rst_ovf", 32'(ovf_a), 0);
        #2 rst_a = 1;
        tick(2);                                    // two counting cycles
        en_a = 0;
        rd_a_chk("t5_restart", 2'd0, 2);

        // --- Test 2: saturation on a 4-bit counter, pc constant
        en_b = 1; pc_b = 10'd3; tick(20);
        en_b = 0;
        chk("t2_ovf", 32'(ovf_b), 32'b00001);
        rd_b_chk("t2_cycles", 3'd0, 15);
        rd_b_chk("t2_instr",  3'd1, 1);
        rd_b_chk("t2_sel_oor", 3'd7, 0);
        rd_b_chk("t2_cycles2", 3'd0, 15);

        // halted in IDLE with enable: straight to DONE, counters stay 0
        clr_b = 1; tick(); clr_b = 0;
        chk("t2_clr_ovf", 32'(ovf_b), 0);
        en_b = 1; hlt_b = 1; tick();
        chk("idle_halt_done", 32'(done_b), 1);
        hlt_b = 0; tick(2); en_b = 0;
        rd_b_chk("idle_halt_cyc", 3'd0, 0);
        chk("idle_halt_done2", 32'(done_b), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Backstop so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule
